// File: rtl/mul_result_drain.sv
// ---------------------------------------------------------------------------
// mul_result_drain
//   Output stage of the sequential multiplier. Captures each 2*M-bit product
//   on the control unit's done pulse into a small FIFO. Each product leaves
//   as two M-bit beats on a valid/ready stream: the low half first, then the
//   high half. res_full tells the control unit to hold off its next start.
//
// Ports
//   clk        in   clock, rising edge
//   nrst       in   asynchronous active-low reset
//   done       in   product valid this cycle (one-cycle pulse)
//   result     in   2*M-bit product
//   res_full   out  FIFO holds DEPTH products; done must not be pulsed
//   overflow   out  sticky flag: a done arrived while res_full was high
//   clr_ovf    in   synchronous clear of overflow (a new overflow wins)
//   out_valid  out  out_data carries a valid beat
//   out_ready  in   sink accepts the beat when out_valid && out_ready
//   out_data   out  current beat (low half, or high half when out_last=1)
//   out_last   out  current beat is the high (final) half of a product
// ---------------------------------------------------------------------------
module mul_result_drain #(
  parameter int M     = 8,
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           done,
  input  logic [2*M-1:0] result,
  output logic           res_full,
  output logic           overflow,
  input  logic           clr_ovf,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M-1:0]   out_data,
  output logic           out_last
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic {
    BEAT_LO = 1'b0,
    BEAT_HI = 1'b1
  } beat_t;

  logic [2*M-1:0] r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  beat_t          r_half_sel;
  logic           r_overflow;

  logic           w_valid;
  logic           w_full;
  logic           w_push;
  logic           w_hs;
  logic           w_pop;
  logic [2*M-1:0] w_head;

  // Everything the stream and the control unit see comes from registered
  // state only, so there is no combinational path from done to any output.
  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CNT_FULL);

  // The push decision uses the registered full flag, i.e. the state before
  // any pop in the same cycle; a simultaneous pop cannot admit an extra push.
  assign w_push  = done && !w_full;
  assign w_hs    = w_valid && out_ready;
  assign w_pop   = w_hs && (r_half_sel == BEAT_HI);

  assign w_head  = r_mem[r_rd_ptr];

  // Product storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= result;
    end
  end

  // Control: pointers, occupancy, beat select and overflow flag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_half_sel <= BEAT_LO;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end

      // Push and pop together leave the occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase

      // Beat FSM: advances only on a handshake; the HI handshake is the pop.
      if (w_hs) begin
        case (r_half_sel)
          BEAT_LO: r_half_sel <= BEAT_HI;
          BEAT_HI: r_half_sel <= BEAT_LO;
          default: r_half_sel <= BEAT_LO;
        endcase
      end

      // A new overflow event takes priority over the clear.
      if (done && w_full) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign res_full  = w_full;
  assign overflow  = r_overflow;
  assign out_valid = w_valid;
  assign out_last  = w_valid && (r_half_sel == BEAT_HI);
  assign out_data  = !w_valid                ? '0 :
                     (r_half_sel == BEAT_HI) ? w_head[2*M-1:M] :
                                               w_head[M-1:0];

endmodule

// File: tb/tb_mul_result_drain.sv
// ---------------------------------------------------------------------------
// tb_mul_result_drain
//   Directed bench for mul_result_drain (M=8, DEPTH=2). Inputs are driven and
//   outputs sampled on the falling clock edge; the DUT acts on rising edges.
// ---------------------------------------------------------------------------
module tb_mul_result_drain;

  localparam int M     = 8;
  localparam int DEPTH = 2;

  logic           clk;
  logic           nrst;
  logic           done;
  logic [2*M-1:0] result;
  logic           res_full;
  logic           overflow;
  logic           clr_ovf;
  logic           out_valid;
  logic           out_ready;
  logic [M-1:0]   out_data;
  logic           out_last;

  int n_chk;
  int n_err;

  mul_result_drain #(.M(M), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .done     (done),
    .result   (result),
    .res_full (res_full),
    .overflow (overflow),
    .clr_ovf  (clr_ovf),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Check the visible beat: valid, data, last.
  task automatic beat(input string tag, input logic v, input logic [7:0] d, input logic l);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_data"},  32'(out_data),  32'(d));
    chk({tag, "_last"},  32'(out_last),  32'(l));
  endtask

  logic [7:0] exp_q [$];
  logic       lst_q [$];

  initial begin
    n_chk     = 0;
    n_err     = 0;
    nrst      = 1'b0;
    done      = 1'b0;
    result    = '0;
    clr_ovf   = 1'b0;
    out_ready = 1'b0;

    // ---- reset state ----
    #2;
    beat("rst", 1'b0, 8'h00, 1'b0);
    chk("rst_full", 32'(res_full), 32'h0);
    chk("rst_ovf",  32'(overflow), 32'h0);
    step();
    nrst = 1'b1;
    step();
    beat("idle", 1'b0, 8'h00, 1'b0);

    // ---- 1: BEEF with out_ready=1 ----
    out_ready = 1'b1;
    done = 1'b1; result = 16'hBEEF;
    step();
    done = 1'b0;
    beat("t1_lo", 1'b1, 8'hEF, 1'b0);
    step();
    beat("t1_hi", 1'b1, 8'hBE, 1'b1);
    step();
    beat("t1_end", 1'b0, 8'h00, 1'b0);

    // ---- 2: backpressure on 1234 ----
    out_ready = 1'b0;
    done = 1'b1; result = 16'h1234;
    step();
    done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      beat("t2_hold", 1'b1, 8'h34, 1'b0);
      step();
    end
    beat("t2_lo", 1'b1, 8'h34, 1'b0);
    out_ready = 1'b1;
    step();
    beat("t2_hi", 1'b1, 8'h12, 1'b1);
    step();
    beat("t2_end", 1'b0, 8'h00, 1'b0);

    // ---- 3: fill, overflow, drain, clear ----
    out_ready = 1'b0;
    done = 1'b1; result = 16'h0001;
    step();
    result = 16'h0002;
    step();
    done = 1'b0;
    chk("t3_full", 32'(res_full), 32'h1);
    chk("t3_noovf", 32'(overflow), 32'h0);
    done = 1'b1; result = 16'h0003;
    step();
    done = 1'b0;
    chk("t3_ovf",   32'(overflow), 32'h1);
    chk("t3_full2", 32'(res_full), 32'h1);
    beat("t3_b0", 1'b1, 8'h01, 1'b0);
    out_ready = 1'b1;
    step();
    beat("t3_b1", 1'b1, 8'h00, 1'b1);
    step();
    beat("t3_b2", 1'b1, 8'h02, 1'b0);
    chk("t3_notfull", 32'(res_full), 32'h0);
    step();
    beat("t3_b3", 1'b1, 8'h00, 1'b1);
    step();
    beat("t3_end", 1'b0, 8'h00, 1'b0);
    chk("t3_ovf_sticky", 32'(overflow), 32'h1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("t3_clr", 32'(overflow), 32'h0);

    // ---- 4: concurrent push/pop, then pointer wrap over 5 products ----
    out_ready = 1'b1;
    done = 1'b1; result = 16'hAAAA;
    step();
    done = 1'b0;
    beat("t4_a_lo", 1'b1, 8'hAA, 1'b0);
    step();
    beat("t4_a_hi", 1'b1, 8'hAA, 1'b1);
    done = 1'b1; result = 16'h5555;
    step();
    done = 1'b0;
    beat("t4_5_lo", 1'b1, 8'h55, 1'b0);
    chk("t4_notfull", 32'(res_full), 32'h0);
    step();
    beat("t4_5_hi", 1'b1, 8'h55, 1'b1);
    step();
    beat("t4_end", 1'b0, 8'h00, 1'b0);

    done = 1'b1; result = {8'hA0, 8'h10};
    step();
    done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      beat("t4w_lo", 1'b1, 8'(8'h10 + k), 1'b0);
      step();
      beat("t4w_hi", 1'b1, 8'(8'hA0 + k), 1'b1);
      if (k < 4) begin
        done = 1'b1;
        result = {8'(8'hA0 + k + 1), 8'(8'h10 + k + 1)};
      end
      step();
      done = 1'b0;
    end
    beat("t4w_end", 1'b0, 8'h00, 1'b0);

    // ---- 5: async reset mid-drain ----
    out_ready = 1'b0;
    done = 1'b1; result = 16'hCAFE;
    step();
    result = 16'h0BAD;
    step();
    result = 16'h0003;
    step();
    done = 1'b0;
    chk("t5_ovf",  32'(overflow), 32'h1);
    chk("t5_full", 32'(res_full), 32'h1);
    beat("t5_lo", 1'b1, 8'hFE, 1'b0);
    out_ready = 1'b1;
    step();
    beat("t5_hi", 1'b1, 8'hCA, 1'b1);
    #2 nrst = 1'b0;
    #1;
    beat("t5_rst", 1'b0, 8'h00, 1'b0);
    chk("t5_rst_full", 32'(res_full), 32'h0);
    chk("t5_rst_ovf",  32'(overflow), 32'h0);
    step();
    nrst = 1'b1;
    step();
    beat("t5_after", 1'b0, 8'h00, 1'b0);

    // ---- 6: spaced products, random out_ready, scoreboard ----
    begin
      int pushed;
      pushed = 0;
      for (int cyc = 0; cyc < 220; cyc++) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("t6_extra_beat", 32'(out_data), 32'hFFFF_FFFF);
          end else begin
            chk("t6_data", 32'(out_data), 32'(exp_q.pop_front()));
            chk("t6_last", 32'(out_last), 32'(lst_q.pop_front()));
          end
        end
        done = 1'b0;
        if ((cyc % (2 * M)) == 0 && pushed < 10 && !res_full) begin
          done   = 1'b1;
          result = 16'($urandom);
          exp_q.push_back(result[7:0]);  lst_q.push_back(1'b0);
          exp_q.push_back(result[15:8]); lst_q.push_back(1'b1);
          pushed++;
        end
        step();
      end
      done = 1'b0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 20; cyc++) begin
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("t6_extra_beat", 32'(out_data), 32'hFFFF_FFFF);
          end else begin
            chk("t6_data", 32'(out_data), 32'(exp_q.pop_front()));
            chk("t6_last", 32'(out_last), 32'(lst_q.pop_front()));
          end
        end
        step();
      end
      chk("t6_pushed", 32'(pushed), 32'd10);
      chk("t6_left", 32'(exp_q.size()), 32'd0);
      chk("t6_ovf", 32'(overflow), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
